cpu_boot_ctrl: RTL and testbench
================================

// Module: cpu_boot_ctrl
// PURPOSE
// Sequencer that owns the CPU's external memory ports and run enable. On start it streams a program into
// instruction memory, zero-fills data memory, releases the CPU from reset and runs it for a bounded
// cycle count, then halts it and reports done. Sits between the test/host interface and the cpu top.
// PARAMETERS
// IMEM_WORDS  128  32-bit words in instruction memory (byte address = index*4)
// DMEM_WORDS  128  64-bit words in data memory (byte address = index*8)
// CNT_W       32   width of run-cycle limit and cycle counter
// PORTS
// clk          in   1      main clock
// arst_n       in   1      asynchronous reset, active low
// start        in   1      one-cycle pulse; begins a load/clear/run sequence
// abort        in   1      level; cancels any sequence in progress
// prog_len     in   $clog2(IMEM_WORDS+1)  words to load; sampled on accepted start
// run_cycles   in   CNT_W  cycles to run; 0 = run until abort; sampled on accepted start
// s_valid      in   1      program word valid
// s_ready      out  1      program word accepted when s_valid&&s_ready
// s_data       in   32     program word
// imem_addr    out  64     instruction memory external address (cpu addr_ext)
// imem_wen     out  1      instruction memory external write enable
// imem_wdata   out  32     instruction memory external write data
// dmem_addr    out  64     data memory external address (cpu addr_ext_2)
// dmem_wen     out  1      data memory external write enable
// dmem_wdata   out  64     data memory external write data (always 0)
// cpu_rst_n    out  1      CPU reset, active low, registered
// cpu_enable   out  1      CPU run enable, registered
// busy         out  1      high in LOAD, CLEAR, RUN
// done         out  1      high in DONE
// cycle_count  out  CNT_W  enabled cycles in current/last run
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0 (cpu_rst_n=0 holds CPU in reset); index and counters 0.
// - States: IDLE, LOAD, CLEAR, RUN, DONE. Registered one-hot or binary; encoding from package.
// - IDLE/DONE + start: latch prog_len (clamped to IMEM_WORDS) and run_cycles; cpu_rst_n<=0,
//   cpu_enable<=0, cycle_count<=0, index<=0; go LOAD, or CLEAR if clamped prog_len==0. start ignored elsewhere.
// - LOAD: s_ready = (state==LOAD), combinational. Handshake in cycle t -> cycle t+1: imem_wen=1,
//   imem_addr=index*4, imem_wdata=s_data; index++. Handshake on word prog_len-1 -> CLEAR next cycle,
//   index<=0. s_valid low stalls with no write; imem_wen is a single-cycle pulse per word.
// - CLEAR: one write per cycle, dmem_wen=1, dmem_addr=index*8, dmem_wdata=0, for exactly DMEM_WORDS
//   consecutive cycles (index 0..DMEM_WORDS-1); no imem/dmem write overlap. Then RUN.
// - RUN: entry cycle cpu_rst_n<=1; cpu_enable<=1 one cycle later (CPU leaves reset one cycle before
//   first enabled edge). cycle_count increments every cycle cpu_enable==1, wrapping at 2^CNT_W.
//   When run_cycles!=0 and cycle_count reaches run_cycles: cpu_enable<=0 same edge, go DONE;
//   exactly run_cycles enabled cycles. run_cycles==0: RUN until abort.
// - DONE: done=1, cpu_enable=0, cpu_rst_n stays 1 so memories/registers remain readable; cycle_count held.
// - abort (highest priority, any state but IDLE): next cycle IDLE, cpu_enable=0, cpu_rst_n=0, all
//   writes deasserted, s_ready=0; cycle_count held. abort and start in same cycle: abort wins.
// - arst_n mid-sequence: immediate return to reset values; partial memory contents undefined.
// - External memory ports driven 0 except during their write cycles; host reads via cpu read ports
//   only while not busy.
// STRUCTURE
// - Package cpu_boot_pkg: state encoding localparams, IMEM_BYTES_PER_WORD=4, DMEM_BYTES_PER_WORD=8.
// - One sub-module boot_index_counter: clearable, enabled up-counter with terminal-count compare,
//   shared by LOAD and CLEAR. Run counter and FSM stay in top.
// TESTING
// - prog_len=4, s_valid always 1, words A0..A3 -> imem writes at addr 0,4,8,12 on 4 consecutive
//   cycles; then 128 dmem_wen pulses at addr 0..1016 step 8, data 0.
// - s_valid toggled 1,0,0,1 during LOAD -> no imem_wen in stalled cycles; addresses remain contiguous.
// - run_cycles=10 -> cpu_rst_n rises one cycle before cpu_enable; enable high exactly 10 cycles;
//   cycle_count=10, done=1, busy=0.
// - run_cycles=0, abort after 50 cycles -> cpu_enable drops next cycle, cpu_rst_n=0, IDLE, cycle_count=50.
// - prog_len=0 and prog_len=200 -> no imem writes / exactly 128 writes (addr 0..508), then normal CLEAR.
// - start during LOAD ignored; arst_n low during CLEAR -> all outputs 0 immediately; new start restarts at index 0.

Source files
------------

// File: rtl/cpu_boot_ctrl_pkg.sv
// Package cpu_boot_pkg: shared definitions for the CPU boot sequencer.
//   - default sizes for instruction/data memory and the run counter
//   - byte strides of the two memories
//   - FSM state encoding
//   - helper turning a word index into a byte address
package cpu_boot_pkg;

   localparam int IMEM_WORDS_DEF      = 128;
   localparam int DMEM_WORDS_DEF      = 128;
   localparam int CNT_W_DEF           = 32;
   localparam int IMEM_BYTES_PER_WORD = 4;
   localparam int DMEM_BYTES_PER_WORD = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_CLEAR = 3'd2,
      ST_RUN   = 3'd3,
      ST_DONE  = 3'd4
   } boot_state_e;

   // Byte address of word 'idx' in a memory with the given word stride.
   function automatic logic [63:0] word_byte_addr(input logic [63:0] idx,
                                                  input int unsigned bytes_per_word);
      return idx * 64'(bytes_per_word);
   endfunction

endpackage

// File: rtl/cpu_boot_ctrl_if.sv
// Interface cpu_boot_ctrl_if: program stream and external memory write ports of the boot sequencer.
//   s_valid/s_data/s_ready           program word stream (host -> sequencer)
//   imem_addr/imem_wen/imem_wdata    instruction memory external write port
//   dmem_addr/dmem_wen/dmem_wdata    data memory external write port
// modport master: the sequencer side; modport slave: host + CPU memory side.
interface cpu_boot_ctrl_if;

   logic        s_valid;
   logic        s_ready;
   logic [31:0] s_data;
   logic [63:0] imem_addr;
   logic        imem_wen;
   logic [31:0] imem_wdata;
   logic [63:0] dmem_addr;
   logic        dmem_wen;
   logic [63:0] dmem_wdata;

   modport master (
      input  s_valid, s_data,
      output s_ready, imem_addr, imem_wen, imem_wdata, dmem_addr, dmem_wen, dmem_wdata
   );

   modport slave (
      output s_valid, s_data,
      input  s_ready, imem_addr, imem_wen, imem_wdata, dmem_addr, dmem_wen, dmem_wdata
   );

endinterface

// File: rtl/cpu_boot_ctrl_index_counter.sv
// boot_index_counter: clearable, enabled up-counter with terminal-count compare.
// Walks the word index during program load and data-memory clear.
//   clk, arst_n   clock, asynchronous active-low reset
//   clr_i         synchronous clear (wins over en_i)
//   en_i          advance by one
//   term_i        terminal value; tc_o = (count_o == term_i)
//   count_o       current index
module boot_index_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         arst_n,
   input  logic         clr_i,
   input  logic         en_i,
   input  logic [W-1:0] term_i,
   output logic [W-1:0] count_o,
   output logic         tc_o
);

   logic [W-1:0] count_q;

   // Index register: clear has priority over advance.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         count_q <= {W{1'b0}};
      end else if (clr_i) begin
         count_q <= {W{1'b0}};
      end else if (en_i) begin
         count_q <= count_q + W'(1);
      end
   end

   assign count_o = count_q;
   assign tc_o    = (count_q == term_i);

endmodule

// File: rtl/cpu_boot_ctrl.sv
// cpu_boot_ctrl: owns the CPU's external memory ports and run enable.
// On start: stream prog_len words into instruction memory, zero-fill all of data memory,
// release the CPU from reset, run it for run_cycles enabled cycles (0 = until abort), then halt.
//   clk, arst_n          clock, asynchronous active-low reset
//   start, abort         one-cycle start pulse; level abort (wins over start)
//   prog_len, run_cycles sequence parameters, sampled on an accepted start
//   bus                  program stream + imem/dmem external write ports
//   cpu_rst_n, cpu_enable CPU reset (active low) and run enable
//   busy, done           status (busy in LOAD/CLEAR/RUN, done in DONE)
//   cycle_count          enabled cycles in the current/last run
module cpu_boot_ctrl
   import cpu_boot_pkg::*;
#(
   parameter int IMEM_WORDS = IMEM_WORDS_DEF,
   parameter int DMEM_WORDS = DMEM_WORDS_DEF,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic                          clk,
   input  logic                          arst_n,
   input  logic                          start,
   input  logic                          abort,
   input  logic [$clog2(IMEM_WORDS+1)-1:0] prog_len,
   input  logic [CNT_W-1:0]              run_cycles,
   cpu_boot_ctrl_if.master               bus,
   output logic                          cpu_rst_n,
   output logic                          cpu_enable,
   output logic                          busy,
   output logic                          done,
   output logic [CNT_W-1:0]              cycle_count
);

   localparam int PL_W    = $clog2(IMEM_WORDS + 1);
   localparam int MAX_WDS = (IMEM_WORDS > DMEM_WORDS) ? IMEM_WORDS : DMEM_WORDS;
   localparam int IDX_W   = $clog2(MAX_WDS + 1);

   boot_state_e      state_q;
   logic [PL_W-1:0]  prog_len_q;
   logic [PL_W-1:0]  prog_len_d;
   logic [CNT_W-1:0] run_cycles_q;
   logic [CNT_W-1:0] cycle_count_q;
   logic [CNT_W-1:0] cycle_count_d;
   logic             imem_wen_q;
   logic [63:0]      imem_addr_q;
   logic [31:0]      imem_wdata_q;
   logic             dmem_wen_q;
   logic [63:0]      dmem_addr_q;
   logic             cpu_rst_n_q;
   logic             cpu_enable_q;
   logic             busy_q;
   logic             done_q;

   logic             idx_clr_s;
   logic             idx_en_s;
   logic [IDX_W-1:0] idx_term_s;
   logic [IDX_W-1:0] idx_s;
   logic             idx_tc_s;

   assign prog_len_d    = (prog_len > PL_W'(IMEM_WORDS)) ? PL_W'(IMEM_WORDS) : prog_len;
   assign cycle_count_d = cycle_count_q + CNT_W'(1);

   // Index counter control: only LOAD and CLEAR walk the index; it is parked at 0 elsewhere.
   always_comb begin
      idx_clr_s  = 1'b1;
      idx_en_s   = 1'b0;
      idx_term_s = {IDX_W{1'b0}};
      case (state_q)
         ST_LOAD: begin
            idx_term_s = IDX_W'(prog_len_q) - IDX_W'(1);
            idx_en_s   = bus.s_valid;
            idx_clr_s  = abort | (bus.s_valid & idx_tc_s);
         end
         ST_CLEAR: begin
            idx_term_s = IDX_W'(DMEM_WORDS - 1);
            idx_en_s   = 1'b1;
            idx_clr_s  = abort | idx_tc_s;
         end
         default: begin
            idx_clr_s  = 1'b1;
            idx_en_s   = 1'b0;
            idx_term_s = {IDX_W{1'b0}};
         end
      endcase
   end

   boot_index_counter #(.W(IDX_W)) u_index (
      .clk     (clk),
      .arst_n  (arst_n),
      .clr_i   (idx_clr_s),
      .en_i    (idx_en_s),
      .term_i  (idx_term_s),
      .count_o (idx_s),
      .tc_o    (idx_tc_s)
   );

   // Sequencer FSM with registered memory-port, CPU-control and status outputs.
   // Memory write strobes default low every cycle so each write is a single-cycle pulse;
   // the dmem write for a CLEAR cycle appears one cycle later, which keeps it clear of the
   // final imem write.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q       <= ST_IDLE;
         prog_len_q    <= {PL_W{1'b0}};
         run_cycles_q  <= {CNT_W{1'b0}};
         cycle_count_q <= {CNT_W{1'b0}};
         imem_wen_q    <= 1'b0;
         imem_addr_q   <= 64'd0;
         imem_wdata_q  <= 32'd0;
         dmem_wen_q    <= 1'b0;
         dmem_addr_q   <= 64'd0;
         cpu_rst_n_q   <= 1'b0;
         cpu_enable_q  <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         imem_wen_q   <= 1'b0;
         imem_addr_q  <= 64'd0;
         imem_wdata_q <= 32'd0;
         dmem_wen_q   <= 1'b0;
         dmem_addr_q  <= 64'd0;
         if (abort && (state_q != ST_IDLE)) begin
            // cycle_count is deliberately held for post-mortem reads
            state_q      <= ST_IDLE;
            cpu_rst_n_q  <= 1'b0;
            cpu_enable_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE, ST_DONE: begin
                  if (start) begin
                     prog_len_q    <= prog_len_d;
                     run_cycles_q  <= run_cycles;
                     cycle_count_q <= {CNT_W{1'b0}};
                     cpu_rst_n_q   <= 1'b0;
                     cpu_enable_q  <= 1'b0;
                     busy_q        <= 1'b1;
                     done_q        <= 1'b0;
                     state_q       <= (prog_len_d == {PL_W{1'b0}}) ? ST_CLEAR : ST_LOAD;
                  end
               end
               ST_LOAD: begin
                  if (bus.s_valid) begin
                     imem_wen_q   <= 1'b1;
                     imem_addr_q  <= word_byte_addr(64'(idx_s), IMEM_BYTES_PER_WORD);
                     imem_wdata_q <= bus.s_data;
                     if (idx_tc_s) begin
                        state_q <= ST_CLEAR;
                     end
                  end
               end
               ST_CLEAR: begin
                  dmem_wen_q  <= 1'b1;
                  dmem_addr_q <= word_byte_addr(64'(idx_s), DMEM_BYTES_PER_WORD);
                  if (idx_tc_s) begin
                     state_q     <= ST_RUN;
                     cpu_rst_n_q <= 1'b1;
                  end
               end
               ST_RUN: begin
                  // Enable is low only in the first RUN cycle: CPU leaves reset one cycle
                  // before its first enabled edge.
                  if (!cpu_enable_q) begin
                     cpu_enable_q <= 1'b1;
                  end else begin
                     cycle_count_q <= cycle_count_d;
                     if ((run_cycles_q != {CNT_W{1'b0}}) && (cycle_count_d == run_cycles_q)) begin
                        cpu_enable_q <= 1'b0;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                        state_q      <= ST_DONE;
                     end
                  end
               end
               default: begin
                  state_q      <= ST_IDLE;
                  cpu_rst_n_q  <= 1'b0;
                  cpu_enable_q <= 1'b0;
                  busy_q       <= 1'b0;
                  done_q       <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.s_ready    = (state_q == ST_LOAD);
   assign bus.imem_wen   = imem_wen_q;
   assign bus.imem_addr  = imem_addr_q;
   assign bus.imem_wdata = imem_wdata_q;
   assign bus.dmem_wen   = dmem_wen_q;
   assign bus.dmem_addr  = dmem_addr_q;
   assign bus.dmem_wdata = 64'd0;
   assign cpu_rst_n      = cpu_rst_n_q;
   assign cpu_enable     = cpu_enable_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign cycle_count    = cycle_count_q;

endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// Testbench for cpu_boot_ctrl: directed sequences; expected imem/dmem writes are queued when
// stimulus is issued and a negedge monitor pops and compares every write the DUT presents.
module tb_cpu_boot_ctrl;

   localparam int DMEM_W = 128;

   logic        clk;
   logic        arst_n;
   logic        start;
   logic        abort;
   logic [7:0]  prog_len;
   logic [31:0] run_cycles;
   logic        cpu_rst_n;
   logic        cpu_enable;
   logic        busy;
   logic        done;
   logic [31:0] cycle_count;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [63:0] addr;
      logic [31:0] data;
   } imem_exp_t;

   imem_exp_t   exp_imem[$];
   logic [63:0] exp_dmem[$];
   imem_exp_t   mon_e;
   logic [63:0] mon_a;

   cpu_boot_ctrl_if bus();

   cpu_boot_ctrl dut (
      .clk         (clk),
      .arst_n      (arst_n),
      .start       (start),
      .abort       (abort),
      .prog_len    (prog_len),
      .run_cycles  (run_cycles),
      .bus         (bus),
      .cpu_rst_n   (cpu_rst_n),
      .cpu_enable  (cpu_enable),
      .busy        (busy),
      .done        (done),
      .cycle_count (cycle_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Write monitor: every presented write must match the head of its queue; idle ports read 0.
   always @(negedge clk) begin
      if (arst_n) begin
         if (bus.imem_wen) begin
            chk("imem_write_expected", 64'(exp_imem.size() != 0), 64'd1);
            if (exp_imem.size() != 0) begin
               mon_e = exp_imem.pop_front();
               chk("imem_addr", bus.imem_addr, mon_e.addr);
               chk("imem_wdata", 64'(bus.imem_wdata), 64'(mon_e.data));
            end
         end else begin
            chk("imem_idle_zero", bus.imem_addr | 64'(bus.imem_wdata), 64'd0);
         end
         if (bus.dmem_wen) begin
            chk("dmem_write_expected", 64'(exp_dmem.size() != 0), 64'd1);
            if (exp_dmem.size() != 0) begin
               mon_a = exp_dmem.pop_front();
               chk("dmem_addr", bus.dmem_addr, mon_a);
               chk("dmem_wdata", bus.dmem_wdata, 64'd0);
            end
         end else begin
            chk("dmem_idle_zero", bus.dmem_addr | bus.dmem_wdata, 64'd0);
         end
         if (bus.imem_wen || bus.dmem_wen) begin
            chk("write_overlap", 64'(bus.imem_wen & bus.dmem_wen), 64'd0);
         end
      end
   end

   task automatic do_start(input int plen, input int rc);
      @(negedge clk);
      start      = 1'b1;
      prog_len   = 8'(plen);
      run_cycles = 32'(rc);
      @(negedge clk);
      start      = 1'b0;
   endtask

   // Offer words A0,A1,... with s_valid following pat (bit k%4); optionally pulse start mid-load.
   task automatic load_words(input int n, input logic [3:0] pat, input bit poke);
      int k   = 0;
      int acc = 0;
      while (acc < n && k < 2000) begin
         bus.s_valid = pat[k % 4];
         bus.s_data  = 32'hA0 + 32'(acc);
         if (poke && k == 1) begin
            start    = 1'b1;
            prog_len = 8'd7;
         end else begin
            start    = 1'b0;
         end
         if (bus.s_valid && bus.s_ready) begin
            exp_imem.push_back('{addr: 64'(acc * 4), data: 32'hA0 + 32'(acc)});
            acc++;
         end
         k++;
         @(negedge clk);
      end
      bus.s_valid = 1'b0;
      start       = 1'b0;
      chk("load_words_accepted", 64'(acc), 64'(n));
   endtask

   task automatic wait_done(input int rc);
      int cyc = 0;
      int rst_rise = -1;
      int en_rise = -1;
      int en_cyc = 0;
      while (!done && cyc < 5000) begin
         if (cpu_rst_n && rst_rise < 0) rst_rise = cyc;
         if (cpu_enable) begin
            if (en_rise < 0) en_rise = cyc;
            en_cyc++;
         end
         cyc++;
         @(negedge clk);
      end
      chk("done_reached", 64'(done), 64'd1);
      chk("rst_before_enable", 64'(en_rise - rst_rise), 64'd1);
      chk("enabled_cycles", 64'(en_cyc), 64'(rc));
      chk("cycle_count_done", 64'(cycle_count), 64'(rc));
      chk("busy_done", 64'(busy), 64'd0);
      chk("cpu_rst_n_done", 64'(cpu_rst_n), 64'd1);
      chk("cpu_enable_done", 64'(cpu_enable), 64'd0);
   endtask

   task automatic run_seq(input int plen, input int rc, input logic [3:0] pat, input bit poke);
      int n = (plen > 128) ? 128 : plen;
      for (int i = 0; i < DMEM_W; i++) exp_dmem.push_back(64'(i * 8));
      do_start(plen, rc);
      chk("busy_after_start", 64'(busy), 64'd1);
      chk("cpu_rst_n_after_start", 64'(cpu_rst_n), 64'd0);
      load_words(n, pat, poke);
      wait_done(rc);
      chk("imem_queue_drained", 64'(exp_imem.size()), 64'd0);
      chk("dmem_queue_drained", 64'(exp_dmem.size()), 64'd0);
   endtask

   initial begin
      int cyc;
      int en_cyc;
      start       = 1'b0;
      abort       = 1'b0;
      prog_len    = 8'd0;
      run_cycles  = 32'd0;
      bus.s_valid = 1'b0;
      bus.s_data  = 32'd0;
      arst_n      = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
      chk("rst_cpu_enable", 64'(cpu_enable), 64'd0);
      chk("rst_busy_done", 64'({busy, done}), 64'd0);
      chk("rst_cycle_count", 64'(cycle_count), 64'd0);
      chk("rst_s_ready", 64'(bus.s_ready), 64'd0);
      arst_n = 1'b1;
      @(negedge clk);

      // Back-to-back load, then stalled load with a start pulse that must be ignored.
      run_seq(4, 10, 4'b1111, 1'b0);
      run_seq(4, 10, 4'b1001, 1'b1);

      // Run until abort: abort raised once 50 enabled edges have completed.
      for (int i = 0; i < DMEM_W; i++) exp_dmem.push_back(64'(i * 8));
      do_start(3, 0);
      load_words(3, 4'b1111, 1'b0);
      cyc    = 0;
      en_cyc = 0;
      while (cyc < 2000) begin
         if (cpu_enable) en_cyc++;
         if (en_cyc == 51) break;
         cyc++;
         @(negedge clk);
      end
      chk("abort_run_reached", 64'(en_cyc), 64'd51);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_cpu_enable", 64'(cpu_enable), 64'd0);
      chk("abort_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
      chk("abort_busy_done", 64'({busy, done}), 64'd0);
      chk("abort_cycle_count", 64'(cycle_count), 64'd50);
      chk("abort_s_ready", 64'(bus.s_ready), 64'd0);
      chk("abort_dmem_drained", 64'(exp_dmem.size()), 64'd0);

      // Empty program and over-long program (clamped to 128 words).
      run_seq(0, 3, 4'b1111, 1'b0);
      run_seq(200, 3, 4'b1111, 1'b0);

      // Asynchronous reset in the middle of CLEAR, then a fresh sequence from index 0.
      for (int i = 0; i < DMEM_W; i++) exp_dmem.push_back(64'(i * 8));
      do_start(0, 5);
      repeat (20) @(negedge clk);
      #2 arst_n = 1'b0;
      #1;
      chk("arst_dmem_wen", 64'(bus.dmem_wen), 64'd0);
      chk("arst_dmem_addr", bus.dmem_addr, 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_cpu_ctrl", 64'({cpu_rst_n, cpu_enable}), 64'd0);
      chk("arst_cycle_count", 64'(cycle_count), 64'd0);
      exp_dmem.delete();
      exp_imem.delete();
      @(negedge clk);
      arst_n = 1'b1;
      @(negedge clk);
      run_seq(2, 4, 4'b1111, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
